// File: rtl/lighthouse_ootx_pkg.sv
// Shared types, constants and frame-size helpers for the lighthouse OOTX encoder.
// The optional internal CRC (macro OOTX_ENCODER_CRC_EN) uses the CRC32_* constants.
package lighthouse_ootx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_WORD,
      ST_SYNC
   } ootx_state_t;

   localparam int PREAMBLE_ZEROS = 17;
   localparam int WORD_BITS      = 16;

   localparam logic [31:0] CRC32_POLY   = 32'hEDB8_8320;
   localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC32_XOROUT = 32'hFFFF_FFFF;

   function automatic int payload_words(input int payload_bytes);
      return (payload_bytes + 1) / 2;
   endfunction

   // Preamble plus sync-terminated length, payload and two CRC words.
   function automatic int frame_bits(input int payload_bytes);
      return PREAMBLE_ZEROS + 1 + (WORD_BITS + 1) * (1 + payload_words(payload_bytes) + 2);
   endfunction

endpackage

// File: rtl/ootx_crc32_serial.sv
// Bit-serial reflected CRC-32 over a latched byte vector, byte 0 first, LSB first.
// Only instantiated when OOTX_ENCODER_CRC_EN is defined.
module ootx_crc32_serial
   import lighthouse_ootx_pkg::*;
#(
   parameter int NBYTES = 33
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic [8*NBYTES-1:0] data,
   output logic                busy,
   output logic [31:0]         crc_o
);

   localparam int NBITS = 8 * NBYTES;
   localparam int CNT_W = $clog2(NBITS + 1);

   logic [NBITS-1:0] shift;
   logic [CNT_W-1:0] remaining;
   logic [31:0]      crc;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shift     <= '0;
         remaining <= '0;
         crc       <= '0;
      end else if (start) begin
         shift     <= data;
         remaining <= CNT_W'(NBITS);
         crc       <= CRC32_INIT;
      end else if (remaining != '0) begin
         shift     <= shift >> 1;
         remaining <= remaining - 1'b1;
         crc       <= (crc >> 1) ^ ((crc[0] ^ shift[0]) ? CRC32_POLY : 32'h0);
      end
   end

   assign busy  = (remaining != '0);
   assign crc_o = crc ^ CRC32_XOROUT;

endmodule

// File: rtl/lighthouse_ootx_encoder.sv
// OOTX frame serializer: preamble, length, payload and CRC words, one bit per strobe.
// Define OOTX_ENCODER_CRC_EN to compute the CRC internally instead of using crc32_i.
module lighthouse_ootx_encoder
   import lighthouse_ootx_pkg::*;
#(
   parameter int PAYLOAD_BYTES = 33
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [8*PAYLOAD_BYTES-1:0] payload_i,
   input  logic [31:0]                crc32_i,
   input  logic                       load,
   input  logic                       bit_strobe,
   output logic                       ootx_bit,
   output logic                       bit_valid,
   output logic                       busy,
   output logic                       frame_done
);

   // state       | meaning
   // ST_IDLE     | waiting for load; busy held one extra cycle after a frame
   // ST_PREAMBLE | 17 zeros then a one, bit_cnt 0..17
   // ST_WORD     | 16 data bits of word word_idx, MSB of first byte first
   // ST_SYNC     | single 1 after each word; last CRC word ends the frame

   localparam int NPW    = payload_words(PAYLOAD_BYTES);
   localparam int NW     = NPW + 3;
   localparam int WIDX_W = $clog2(NW);

   localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(NW - 1);
   localparam logic [15:0]       LEN_WORD  = {8'(PAYLOAD_BYTES), 8'(PAYLOAD_BYTES >> 8)};

   ootx_state_t               state;
   logic [4:0]                bit_cnt;
   logic [WIDX_W-1:0]         word_idx;
   logic [8*PAYLOAD_BYTES-1:0] payload_q;
   logic [16*NPW-1:0]         padded;
   logic [31:0]               crc_field;
   logic [15:0]               cur_word;
   logic                      load_ok;

   assign load_ok = load && (state == ST_IDLE) && !busy;

`ifdef OOTX_ENCODER_CRC_EN
   logic crc_busy;

   ootx_crc32_serial #(
      .NBYTES (PAYLOAD_BYTES)
   ) u_crc (
      .clock (clock),
      .reset (reset),
      .start (load_ok),
      .data  (payload_i),
      .busy  (crc_busy),
      .crc_o (crc_field)
   );
`else
   logic [31:0] crc_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         crc_q <= '0;
      end else if (load_ok) begin
         crc_q <= crc32_i;
      end
   end

   assign crc_field = crc_q;
`endif

   // An odd payload gets a trailing 0x00 pad byte in its last word.
   always_comb begin
      padded = '0;
      padded[8*PAYLOAD_BYTES-1:0] = payload_q;
   end

   // Earlier byte of each pair sits in [15:8] so the word shifts out MSB-first.
   always_comb begin
      cur_word = LEN_WORD;
      for (int i = 0; i < NPW; i++) begin
         if (word_idx == WIDX_W'(i + 1)) begin
            cur_word = {padded[16*i +: 8], padded[16*i+8 +: 8]};
         end
      end
      if (word_idx == WIDX_W'(NPW + 1)) begin
         cur_word = {crc_field[7:0], crc_field[15:8]};
      end
      if (word_idx == WIDX_W'(NPW + 2)) begin
         cur_word = {crc_field[23:16], crc_field[31:24]};
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         bit_cnt    <= '0;
         word_idx   <= '0;
         payload_q  <= '0;
         ootx_bit   <= 1'b0;
         bit_valid  <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         bit_valid  <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               busy <= 1'b0;
               if (load_ok) begin
                  state     <= ST_PREAMBLE;
                  busy      <= 1'b1;
                  payload_q <= payload_i;
                  bit_cnt   <= '0;
                  word_idx  <= '0;
               end
            end
            ST_PREAMBLE: begin
               if (bit_strobe) begin
                  bit_valid <= 1'b1;
                  ootx_bit  <= (bit_cnt == 5'(PREAMBLE_ZEROS));
                  if (bit_cnt == 5'(PREAMBLE_ZEROS)) begin
                     state   <= ST_WORD;
                     bit_cnt <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            ST_WORD: begin
               if (bit_strobe) begin
                  bit_valid <= 1'b1;
                  ootx_bit  <= cur_word[~bit_cnt[3:0]];
                  if (bit_cnt == 5'(WORD_BITS - 1)) begin
                     state   <= ST_SYNC;
                     bit_cnt <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            ST_SYNC: begin
               if (bit_strobe) begin
                  bit_valid <= 1'b1;
                  ootx_bit  <= 1'b1;
                  if (word_idx == LAST_WORD) begin
                     state      <= ST_IDLE;
                     frame_done <= 1'b1;
                  end else begin
                     word_idx <= word_idx + 1'b1;
                     state    <= ST_WORD;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lighthouse_ootx_encoder.sv
// Directed bench for lighthouse_ootx_encoder; CRC expectations follow OOTX_ENCODER_CRC_EN.
module tb_lighthouse_ootx_encoder;

   localparam int PB = 33;
   localparam int FB = 358;

   logic            clock;
   logic            reset;
   logic [8*PB-1:0] payload_i;
   logic [31:0]     crc32_i;
   logic            load;
   logic            bit_strobe;
   logic            ootx_bit;
   logic            bit_valid;
   logic            busy;
   logic            frame_done;

   int vectors;
   int miscompares;

   logic obs_bit   [FB];
   logic obs_valid [FB];
   logic obs_done  [FB];
   logic obs_busy  [FB];

   lighthouse_ootx_encoder #(.PAYLOAD_BYTES(PB)) dut (
      .clock      (clock),
      .reset      (reset),
      .payload_i  (payload_i),
      .crc32_i    (crc32_i),
      .load       (load),
      .bit_strobe (bit_strobe),
      .ootx_bit   (ootx_bit),
      .bit_valid  (bit_valid),
      .busy       (busy),
      .frame_done (frame_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [FB-1:0] got, input logic [FB-1:0] exp);
      vectors++;
      assert (got === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] crc32_model(input logic [8*PB-1:0] p);
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      for (int k = 0; k < PB; k++) begin
         c = c ^ {24'h0, p[8*k +: 8]};
         for (int j = 0; j < 8; j++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
         end
      end
      return ~c;
   endfunction

   function automatic logic [31:0] expected_crc(input logic [8*PB-1:0] p, input logic [31:0] c);
`ifdef OOTX_ENCODER_CRC_EN
      return crc32_model(p);
`else
      return c;
`endif
   endfunction

   function automatic logic [FB-1:0] model_frame(input logic [8*PB-1:0] p, input logic [31:0] c);
      logic [7:0]    bl [40];
      logic [FB-1:0] f;
      int            pos;
      f = '0;
      bl[0] = 8'(PB);
      bl[1] = 8'h00;
      for (int k = 0; k < PB; k++) bl[2+k] = p[8*k +: 8];
      bl[35] = 8'h00;
      bl[36] = c[7:0];
      bl[37] = c[15:8];
      bl[38] = c[23:16];
      bl[39] = c[31:24];
      f[17] = 1'b1;
      pos = 18;
      for (int w = 0; w < 20; w++) begin
         for (int b = 0; b < 2; b++) begin
            for (int j = 7; j >= 0; j--) begin
               f[pos] = bl[2*w+b][j];
               pos++;
            end
         end
         f[pos] = 1'b1;
         pos++;
      end
      return f;
   endfunction

   function automatic logic [8*PB-1:0] rand_payload();
      logic [8*PB-1:0] p;
      for (int k = 0; k < PB; k++) p[8*k +: 8] = 8'($urandom);
      return p;
   endfunction

   // Word k of the frame (0 = length) as sent, first bit in [15].
   function automatic logic [15:0] get_word(input int k);
      logic [15:0] w;
      for (int i = 0; i < 16; i++) w[15-i] = obs_bit[18 + 17*k + i];
      return w;
   endfunction

   // Entered and left at a falling edge; samples outputs one cycle after each strobe.
   task automatic run_bits(input int gap, input int first, input int count);
      for (int i = 0; i < count; i++) begin
         bit_strobe = 1'b1;
         @(negedge clock);
         bit_strobe = 1'b0;
         load       = 1'b0;
         obs_bit[first+i]   = ootx_bit;
         obs_valid[first+i] = bit_valid;
         obs_done[first+i]  = frame_done;
         obs_busy[first+i]  = busy;
         repeat (gap - 1) @(negedge clock);
      end
   endtask

   task automatic start_frame(input logic [8*PB-1:0] p, input logic [31:0] c, input string tag);
      payload_i = p;
      crc32_i   = c;
      load      = 1'b1;
      @(negedge clock);
      load = 1'b0;
      chk({tag, " busy after load"}, FB'(busy), FB'(1'b1));
   endtask

   task automatic check_frame(input string tag, input logic [8*PB-1:0] p, input logic [31:0] c);
      logic [FB-1:0] got;
      int vcount, dcount, dpos;
      vcount = 0;
      dcount = 0;
      dpos   = -1;
      for (int i = 0; i < FB; i++) begin
         got[i] = obs_bit[i];
         if (obs_valid[i] === 1'b1) vcount++;
         if (obs_done[i] === 1'b1) begin
            dcount++;
            dpos = i;
         end
      end
      chk({tag, " bits"}, got, model_frame(p, expected_crc(p, c)));
      chk({tag, " valid count"}, FB'(vcount), FB'(FB));
      chk({tag, " done count"}, FB'(dcount), FB'(1));
      chk({tag, " done index"}, FB'(dpos), FB'(FB - 1));
   endtask

   logic [8*PB-1:0] pa, pb, pc, pd;
   logic [31:0]     cexp;
   logic            ok;
   int              stray;

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      payload_i   = '0;
      crc32_i     = '0;
      load        = 1'b0;
      bit_strobe  = 1'b0;
      repeat (3) @(negedge clock);
      chk("reset ootx_bit", FB'(ootx_bit), FB'(1'b0));
      chk("reset bit_valid", FB'(bit_valid), FB'(1'b0));
      chk("reset busy", FB'(busy), FB'(1'b0));
      chk("reset frame_done", FB'(frame_done), FB'(1'b0));
      reset = 1'b0;
      @(negedge clock);

      // Strobes while idle produce nothing.
      run_bits(1, 0, 5);
      stray = 0;
      for (int i = 0; i < 5; i++) if (obs_valid[i] !== 1'b0 || obs_busy[i] !== 1'b0) stray++;
      chk("idle strobes", FB'(stray), FB'(0));

      // Frame A: strobes 4 clocks apart, header fields decoded by hand.
      for (int k = 0; k < PB; k++) pa[8*k +: 8] = 8'(k * 37 + 11);
      start_frame(pa, 32'hDEAD_BEEF, "A");
      run_bits(4, 0, FB);
      ok = 1'b1;
      for (int i = 0; i < 17; i++) if (obs_bit[i] !== 1'b0) ok = 1'b0;
      chk("A preamble zeros", FB'(ok), FB'(1'b1));
      chk("A preamble one", FB'(obs_bit[17]), FB'(1'b1));
      chk("A length word", FB'(get_word(0)), FB'(16'h2100));
      chk("A length sync", FB'(obs_bit[34]), FB'(1'b1));
      check_frame("A", pa, 32'hDEAD_BEEF);
      chk("A busy at last bit", FB'(obs_busy[FB-1]), FB'(1'b1));
      chk("A busy after frame", FB'(busy), FB'(1'b0));

      // Frame B: 0xA5 payload with fixed CRC input.
      for (int k = 0; k < PB; k++) pb[8*k +: 8] = 8'hA5;
      start_frame(pb, 32'h1234_5678, "B");
      run_bits(2, 0, FB);
      ok = 1'b1;
      for (int k = 1; k <= 16; k++) if (get_word(k) !== 16'hA5A5) ok = 1'b0;
      chk("B payload words", FB'(ok), FB'(1'b1));
      chk("B padded word", FB'(get_word(17)), FB'(16'hA500));
      cexp = expected_crc(pb, 32'h1234_5678);
`ifndef OOTX_ENCODER_CRC_EN
      chk("B crc word 0", FB'(get_word(18)), FB'(16'h7856));
      chk("B crc word 1", FB'(get_word(19)), FB'(16'h3412));
`else
      chk("B crc word 0", FB'(get_word(18)), FB'({cexp[7:0], cexp[15:8]}));
      chk("B crc word 1", FB'(get_word(19)), FB'({cexp[23:16], cexp[31:24]}));
`endif
      ok = 1'b1;
      for (int k = 0; k < 20; k++) if (obs_bit[34 + 17*k] !== 1'b1) ok = 1'b0;
      chk("B sync bits", FB'(ok), FB'(1'b1));
      check_frame("B", pb, 32'h1234_5678);

      // Frame C: reload at bit 100 and on the final strobe must both be ignored.
      pc = rand_payload();
      start_frame(pc, 32'hCAFE_F00D, "C");
      run_bits(1, 0, 100);
      payload_i = ~pc;
      crc32_i   = 32'h0BAD_0BAD;
      load      = 1'b1;
      run_bits(1, 100, FB - 101);
      load = 1'b1;
      run_bits(1, FB - 1, 1);
      check_frame("C", pc, 32'hCAFE_F00D);
      stray = 0;
      repeat (2) begin
         @(negedge clock);
         if (busy !== 1'b0 || bit_valid !== 1'b0) stray++;
      end
      run_bits(1, 0, 4);
      for (int i = 0; i < 4; i++) if (obs_valid[i] !== 1'b0 || obs_busy[i] !== 1'b0) stray++;
      chk("C no restart", FB'(stray), FB'(0));

      // Frame D: reset at bit 200, then a clean frame after a new load.
      start_frame(rand_payload(), 32'h5555_AAAA, "D0");
      run_bits(1, 0, 200);
      reset = 1'b1;
      #1;
      chk("D reset outputs", FB'({ootx_bit, bit_valid, busy, frame_done}), FB'(4'b0000));
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("D idle after reset", FB'(busy), FB'(1'b0));
      pd = rand_payload();
      start_frame(pd, 32'h0F1E_2D3C, "D");
      run_bits(3, 0, FB);
      check_frame("D", pd, 32'h0F1E_2D3C);

`ifdef OOTX_ENCODER_CRC_EN
      // Random payloads with back-to-back strobes against the software CRC.
      for (int f = 0; f < 100; f++) begin
         pd = rand_payload();
         start_frame(pd, $urandom, "R");
         run_bits(1, 0, FB);
         cexp = crc32_model(pd);
         chk("R crc", FB'({get_word(18), get_word(19)}),
             FB'({cexp[7:0], cexp[15:8], cexp[23:16], cexp[31:24]}));
         @(negedge clock);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
